// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input valid/ready arbiter feeding a one-word output register.
// Round-robin or fixed-priority selection, one word per cycle sustained.
module rr_arb_mux #(
  parameter int width_size = 2,
  parameter int num_inputs = 4,
  parameter int idx_w      = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                prio_mode,
  input  logic [num_inputs*(width_size+1)-1:0] in_data,
  input  logic [num_inputs-1:0]               in_valid,
  output logic [num_inputs-1:0]               in_ready,
  output logic [width_size:0]                 out_data,
  output logic [idx_w-1:0]                    out_sel,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int DW = width_size + 1;

  if (num_inputs < 2 || num_inputs > 8) begin : g_bad_n
    $error("rr_arb_mux: num_inputs out of range");
  end
  if ((1 << idx_w) < num_inputs) begin : g_bad_idx
    $error("rr_arb_mux: idx_w too small");
  end

  logic [idx_w-1:0] r_ptr;
  logic [DW-1:0]    r_data;
  logic [idx_w-1:0] r_sel;
  logic             r_valid;

  logic             w_can_load;
  logic             w_any;
  logic             w_grant;
  logic             w_hi_found;
  logic [idx_w-1:0] w_hi_idx;
  logic [idx_w-1:0] w_lo_idx;
  logic [idx_w-1:0] w_win;
  logic [idx_w-1:0] w_ptr_nxt;
  logic [DW-1:0]    w_win_data;

  assign w_can_load = !r_valid || out_ready;
  assign w_any      = |in_valid;
  assign w_grant    = !reset && w_can_load && w_any;

  // Search: lowest requester overall, and lowest requester at or above r_ptr.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int k = num_inputs - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        w_lo_idx = idx_w'(k);
        if (idx_w'(k) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = idx_w'(k);
        end
      end
    end
  end

  // Round-robin wraps to the lowest requester when nothing is at/above r_ptr.
  always_comb begin
    w_win = w_lo_idx;
    if (!prio_mode && w_hi_found) begin
      w_win = w_hi_idx;
    end
  end

  // Pointer moves to the channel after the winner, wrapping at num_inputs.
  always_comb begin
    w_ptr_nxt = w_win + idx_w'(1);
    if (w_win == idx_w'(num_inputs - 1)) begin
      w_ptr_nxt = '0;
    end
  end

  // Select the winning channel's data slice.
  always_comb begin
    w_win_data = '0;
    for (int k = 0; k < num_inputs; k++) begin
      if (w_win == idx_w'(k)) begin
        w_win_data = in_data[k*DW +: DW];
      end
    end
  end

  // One-hot grant to the winner, only when the output register can load.
  always_comb begin
    in_ready = '0;
    if (w_grant) begin
      in_ready = num_inputs'(1) << w_win;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (w_grant) begin
      r_data  <= w_win_data;
      r_sel   <= w_win;
      r_valid <= 1'b1;
      if (!prio_mode) begin
        r_ptr <= w_ptr_nxt;
      end
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed scenarios plus randomized traffic
// checked against a channel-level reference model.
module tb_rr_arb_mux;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [31:0] idata;
  logic [3:0]  iv;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        ordy;

  int n_err;
  int n_chk;

  // reference model state
  int       m_ptr;
  logic     m_valid;
  logic [7:0] m_data;
  logic [1:0] m_sel;

  rr_arb_mux #(
    .width_size(7),
    .num_inputs(4),
    .idx_w(2)
  ) dut (
    .clk(clk),
    .reset(rst),
    .prio_mode(mode),
    .in_data(idata),
    .in_valid(iv),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_sel(out_sel),
    .out_valid(out_valid),
    .out_ready(ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int winner();
    for (int k = 0; k < 4; k++) begin
      int c;
      c = mode ? k : (m_ptr + k) % 4;
      if (iv[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    if (rst || !(!m_valid || ordy) || iv == 4'b0000) return 4'b0000;
    return 4'b0001 << winner();
  endfunction

  function automatic void model_edge();
    int w;
    if (rst) begin
      m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_sel = 2'd0;
    end else begin
      w = winner();
      if ((!m_valid || ordy) && w >= 0) begin
        m_data  = idata[w*8 +: 8];
        m_sel   = 2'(w);
        m_valid = 1'b1;
        if (!mode) m_ptr = (w + 1) % 4;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 0; mode = 0; iv = 4'b0010; idata = 32'h11223344; ordy = 0;
    tick();
    rst = 1; iv = 4'b1111;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 0000", in_ready);
    end
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      n_err++;
      $display("FAIL preload: got v=%b d=%h want v=1 d=33", out_valid, out_data);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if ({out_valid, out_sel, out_data} !== {1'b0, 2'd0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_out: got v=%b s=%0d d=%h want 0/0/00",
               out_valid, out_sel, out_data);
    end
    tick();
    rst = 0;
  endtask

  task automatic test_rr_all();
    rst = 1; tick(); rst = 0;
    mode = 0; iv = 4'b1111; idata = 32'hA3A2A1A0; ordy = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if (in_ready !== exp_ready()) begin
        n_err++;
        $display("FAIL rr_ready c%0d: got %b want %b", c, in_ready, exp_ready());
      end
      if (c >= 1) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_sel !== 2'((c - 1) % 4)
            || out_data !== 8'hA0 + 8'((c - 1) % 4)) begin
          n_err++;
          $display("FAIL rr_seq c%0d: got v=%b s=%0d d=%h want v=1 s=%0d",
                   c, out_valid, out_sel, out_data, (c - 1) % 4);
        end
      end
      tick();
    end
  endtask

  task automatic test_fixed();
    mode = 1; iv = 4'b1110; ordy = 1;
    for (int c = 0; c < 5; c++) begin
      idata = $urandom;
      @(negedge clk);
      n_chk++;
      if (in_ready !== 4'b0010) begin
        n_err++;
        $display("FAIL fix_ready c%0d: got %b want 0010", c, in_ready);
      end
      if (c >= 1) begin
        n_chk++;
        if (out_sel !== 2'd1 || out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL fix_sel c%0d: got s=%0d v=%b want 1/1", c, out_sel, out_valid);
        end
      end
      tick();
    end
    // pointer left at 2 by the round-robin run must survive fixed mode
    mode = 0; iv = 4'b1111;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL fix_ptr_kept: got %b want 0100", in_ready);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] d0;
    logic [1:0] s0;
    mode = 0; iv = 4'b0101; ordy = 0;
    @(negedge clk);
    d0 = m_data; s0 = m_sel;
    for (int c = 0; c < 3; c++) begin
      idata = $urandom;
      @(negedge clk);
      n_chk++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1
          || out_data !== d0 || out_sel !== s0) begin
        n_err++;
        $display("FAIL stall c%0d: got r=%b v=%b d=%h s=%0d want 0000/1/%h/%0d",
                 c, in_ready, out_valid, out_data, out_sel, d0, s0);
      end
      tick();
    end
    ordy = 1; idata = 32'h00BB00CC;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL stall_release: got %b want 0001", in_ready);
    end
    tick();
    iv = 4'b0000;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'hCC || out_sel !== 2'd0) begin
      n_err++;
      $display("FAIL stall_newword: got v=%b d=%h s=%0d want 1/cc/0",
               out_valid, out_data, out_sel);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 8'hCC) begin
      n_err++;
      $display("FAIL drain_hold: got v=%b d=%h want 0/cc", out_valid, out_data);
    end
  endtask

  task automatic test_single();
    rst = 1; iv = 4'b0000; tick(); rst = 0;
    mode = 0; ordy = 1; iv = 4'b0100; idata = 32'h115C2233;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_ready: got %b want 0100", in_ready);
    end
    tick();
    iv = 4'b0000;
    @(negedge clk);
    n_chk++;
    if (out_data !== 8'h5C || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL single_out: got d=%h s=%0d v=%b want 5c/2/1",
               out_data, out_sel, out_valid);
    end
    tick();
  endtask

  task automatic test_wrap();
    iv = 4'b0011; ordy = 1; idata = 32'h44332211;
    @(negedge clk);
    n_chk++;
    if (in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL wrap_first: got %b want 0001", in_ready);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (in_ready !== 4'b0010 || out_sel !== 2'd0) begin
      n_err++;
      $display("FAIL wrap_second: got r=%b s=%0d want 0010/0", in_ready, out_sel);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (out_sel !== 2'd1 || out_data !== 8'h22) begin
      n_err++;
      $display("FAIL wrap_out: got s=%0d d=%h want 1/22", out_sel, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      iv    = 4'($urandom);
      idata = $urandom;
      ordy  = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      n_chk++;
      if (in_ready !== exp_ready()) begin
        n_err++;
        $display("FAIL rand_ready c%0d: got %b want %b", c, in_ready, exp_ready());
      end
      n_chk++;
      if ({out_valid, out_sel, out_data} !== {m_valid, m_sel, m_data}) begin
        n_err++;
        $display("FAIL rand_out c%0d: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                 c, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
      end
      tick();
    end
  endtask

  initial begin
    n_err = 0; n_chk = 0;
    rst = 1; mode = 0; iv = 4'b0000; idata = 32'h0; ordy = 0;
    m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_sel = 2'd0;
    repeat (2) tick();
    test_reset();
    test_rr_all();
    test_fixed();
    test_backpressure();
    test_single();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001: Parameter width_size, default 2; data buses SHALL be [width_size:0], i.e. width_size+1 bits wide.
REQ-002: Parameter num_inputs, default 4; legal range 2..8; SHALL be the number of input channels.
REQ-003: Parameter idx_w, default 2; SHALL equal ceil(log2(num_inputs)), minimum 1.
REQ-004: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: prio_mode  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-007: in_data  input  num_inputs*(width_size+1)  flattened channel data; channel i occupies bits [i*(width_size+1) +: width_size+1].
REQ-008: in_valid  input  num_inputs  per-channel request/valid.
REQ-009: in_ready  output  num_inputs  per-channel accept; one-hot or zero.
REQ-010: out_data  output  width_size+1  registered selected data.
REQ-011: out_sel  output  idx_w  registered index of the channel held in out_data.
REQ-012: out_valid  output  1  out_data/out_sel hold a valid word.
REQ-013: out_ready  input  1  downstream accept.

Function
REQ-014: Transfer on input i SHALL occur when in_valid[i] && in_ready[i] at a rising edge; transfer on output SHALL occur when out_valid && out_ready.
REQ-015: can_load = !out_valid || out_ready; in_ready SHALL be combinational and all-zero when can_load = 0.
REQ-016: When can_load = 1 and at least one in_valid is set, exactly one in_ready bit SHALL be asserted, for the winner; when no in_valid is set, in_ready SHALL be all-zero.
REQ-017: Round-robin mode: the winner SHALL be the first channel with in_valid set, searching upward from rr_ptr and wrapping from num_inputs-1 to 0.
REQ-018: Fixed mode: the winner SHALL be the lowest-index channel with in_valid set; rr_ptr SHALL NOT change.
REQ-019: On a round-robin transfer from channel i, rr_ptr SHALL become (i+1) mod num_inputs on the same edge; it SHALL be unchanged when no input transfer occurs.
REQ-020: On an input transfer, out_data and out_sel SHALL be loaded with the winner's data and index, and out_valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-021: Output transfer with no simultaneous input transfer SHALL clear out_valid; out_data/out_sel SHALL hold their last values.
REQ-022: Simultaneous output and input transfers SHALL reload the register with out_valid staying 1, sustaining one word per cycle.
REQ-023: While out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid SHALL remain stable.
REQ-024: A change of prio_mode SHALL take effect in the same cycle's arbitration; rr_ptr SHALL be retained across mode changes.
REQ-025: Input data is not required to be stable while in_ready = 0; only the transferred word is captured.

Reset
REQ-026: While reset = 1 at a rising edge: out_valid = 0, out_data = 0, out_sel = 0, rr_ptr = 0.
REQ-027: While reset = 1, in_ready SHALL be all-zero and no transfer SHALL be counted; a word held in the output register at reset SHALL be discarded.
REQ-028: The first arbitration after reset deasserts SHALL start searching from channel 0.

Verification (num_inputs=4, width_size=7)
REQ-029: Reset mid-stream with out_valid=1 -> next cycle out_valid=0, out_data=8'h00, out_sel=0; in_ready=4'b0000 while reset high.
REQ-030: Round-robin, in_valid=4'b1111, out_ready=1, data 8'hA0..8'hA3 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-031: Fixed mode, in_valid=4'b1110, out_ready=1 -> out_sel stays 1 every cycle; rr_ptr unchanged.
REQ-032: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b0101 -> in_ready=4'b0000, out_data stable; on out_ready=1, in_ready one-hot for the winner and a new word next cycle.
REQ-033: Wrap: rr_ptr=3, in_valid=4'b0011 -> channel 0 wins, rr_ptr becomes 1; next winner is channel 1.
REQ-034: Single request in_valid=4'b0100 with data 8'h5C, out empty -> in_ready=4'b0100, next cycle out_data=8'h5C, out_sel=2, out_valid=1.
